ripple_count_sampler: RTL

RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

---
 rtl/ripple_count_pkg.sv | 18 +
 rtl/sync_2ff.sv | 34 +++
 rtl/ripple_count_sampler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ripple_count_pkg.sv
// ripple_count_pkg
//   Shared definitions for the ripple-counter sampler: FSM state encoding
//   and the default widths of the sampled count and the wrap counter.
package ripple_count_pkg;

    localparam int CNT_W_DEF  = 4;
    localparam int WRAP_W_DEF = 8;

    // Synchronizer depth (s1, s2) plus the compare register (s3).
    localparam int SAMPLE_STAGES = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,  // no value accepted since reset
        ST_TRACK = 2'd1,  // last accepted value already consumed
        ST_PEND  = 2'd2   // sample_val waiting for the consumer
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a multi-bit bus sampled from another clock
//   domain.  Individual bits may resolve on different edges, so the output
//   is only meaningful once it has held still (checked downstream).
// Ports:
//   clk    - destination clock
//   reset  - asynchronous, active-high
//   i_d    - asynchronous input bus
//   o_q    - synchronized bus (second flop)
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
//   Samples a free-running asynchronous ripple counter, filters out values
//   that are still settling, and hands stable counts to a consumer with a
//   valid/ready handshake.  Each accepted change is classified as a wrap
//   (max -> 0), a restart (other -> 0), a normal increment, or a jump.
// Ports:
//   clk           - sampling clock, rising edge
//   reset         - asynchronous, active-high
//   q_in          - raw ripple-counter outputs (async, may glitch)
//   sample_val    - last accepted stable count
//   sample_valid  - sample_val pending for the consumer
//   sample_ready  - consumer takes the pending sample
//   wrap_pulse    - one cycle, on an accepted max -> 0 change
//   wrap_count    - number of wraps, modulo 2^WRAP_W
//   restart_pulse - one cycle, on an accepted non-max -> 0 change
//   jump_err      - sticky, accepted change was neither +1 nor to 0
//   overrun       - sticky, pending sample replaced before it was taken
module ripple_count_sampler
    import ripple_count_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  q_in,
    output logic [CNT_W-1:0]  sample_val,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              restart_pulse,
    output logic              jump_err,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]         w_s2;
    logic [CNT_W-1:0]         r_s3;
    logic [SAMPLE_STAGES-1:0] r_vld_pipe;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0]  r_sample_val;
    logic [WRAP_W-1:0] r_wrap_count;
    logic              r_wrap_pulse;
    logic              r_restart_pulse;
    logic              r_jump_err;
    logic              r_overrun;

    logic             w_stable;
    logic             w_accept;
    logic             w_eval;
    logic [CNT_W-1:0] w_inc;
    logic             w_wrap;
    logic             w_restart;
    logic             w_jump;
    logic             w_overrun;

    sync_2ff #(.WIDTH(CNT_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (q_in),
        .o_q   (w_s2)
    );

    // r_vld_pipe marks which stages hold a real post-reset sample, so the
    // reset zeros in s2/s3 are never mistaken for a stable count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s3       <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_s3       <= w_s2;
            r_vld_pipe <= {r_vld_pipe[SAMPLE_STAGES-2:0], 1'b1};
        end
    end

    assign w_stable = r_vld_pipe[SAMPLE_STAGES-1] && (w_s2 == r_s3);

    // First value after reset is taken as-is; afterwards only changes count.
    assign w_accept  = (r_state == ST_INIT) ? w_stable
                                            : (w_stable && (w_s2 != r_sample_val));
    assign w_eval    = w_accept && (r_state != ST_INIT);
    assign w_inc     = r_sample_val + CNT_W'(1);
    assign w_wrap    = w_eval && (w_s2 == '0) && (r_sample_val == CNT_MAX);
    assign w_restart = w_eval && (w_s2 == '0) && (r_sample_val != CNT_MAX);
    assign w_jump    = w_eval && (w_s2 != '0) && (w_s2 != w_inc);
    assign w_overrun = w_accept && (r_state == ST_PEND) && !sample_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // An acceptance always lands in PEND; ready only drains PEND when no
    // new value arrives on the same edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  if (w_accept) w_next = ST_PEND;
            ST_TRACK: if (w_accept) w_next = ST_PEND;
            ST_PEND: begin
                if (w_accept)          w_next = ST_PEND;
                else if (sample_ready) w_next = ST_TRACK;
            end
            default:  w_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_val    <= '0;
            r_wrap_count    <= '0;
            r_wrap_pulse    <= 1'b0;
            r_restart_pulse <= 1'b0;
            r_jump_err      <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_wrap_pulse    <= w_wrap;
            r_restart_pulse <= w_restart;
            if (w_accept)  r_sample_val <= w_s2;
            if (w_wrap)    r_wrap_count <= r_wrap_count + WRAP_W'(1);
            if (w_jump)    r_jump_err   <= 1'b1;
            if (w_overrun) r_overrun    <= 1'b1;
        end
    end

    assign sample_val    = r_sample_val;
    assign sample_valid  = (r_state == ST_PEND);
    assign wrap_pulse    = r_wrap_pulse;
    assign wrap_count    = r_wrap_count;
    assign restart_pulse = r_restart_pulse;
    assign jump_err      = r_jump_err;
    assign overrun       = r_overrun;

endmodule
